// File: rtl/pbit_local_field.sv
// Serial local-field accumulator for one p-bit: I = h + sum(J_j * m_j), one neighbour per clock,
// saturated to 4-bit signed and held for the downstream comparator stage.
module pbit_local_field #(
    parameter int N  = 4,
    parameter int WW = 4,
    parameter int AW = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         spins_i,
    input  logic                 wr_en_i,
    input  logic [AW-1:0]        wr_addr_i,
    input  logic signed [WW-1:0] wr_data_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic signed [3:0]    field_out_o,
    output logic                 field_valid_o,
    output logic                 sat_o
);

    localparam int AccW = WW + $clog2(N + 1) + 1;
    localparam int IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic signed [AccW-1:0] AccMax = AccW'(7);
    localparam logic signed [AccW-1:0] AccMin = AccW'(-8);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic signed [WW-1:0]   wgt_q [0:N];
    logic [N-1:0]           snap_q, snap_d;
    logic signed [AccW-1:0] acc_q, acc_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic                   busy_q, busy_d;
    logic signed [3:0]      field_q, field_d;
    logic                   valid_q, valid_d;
    logic                   sat_q, sat_d;
    logic                   wr_ok_s;

    function automatic logic signed [AccW-1:0] sext(input logic signed [WW-1:0] w);
        sext = {{(AccW - WW){w[WW-1]}}, w};
    endfunction

    function automatic logic signed [3:0] clip(input logic signed [AccW-1:0] a);
        if (a > AccMax) begin
            clip = 4'b0111;
        end else if (a < AccMin) begin
            clip = 4'b1000;
        end else begin
            clip = a[3:0];
        end
    endfunction

    // Next-state logic; writes are only honoured in IDLE when no pass is being launched.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        field_d = field_q;
        valid_d = 1'b0;
        sat_d   = sat_q;
        wr_ok_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_ACCUM;
                    snap_d  = spins_i;
                    acc_d   = sext(wgt_q[N]);
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    wr_ok_s = wr_en_i;
                end
            end
            ST_ACCUM: begin
                if (snap_q[idx_q]) begin
                    acc_d = acc_q + sext(wgt_q[idx_q]);
                end else begin
                    acc_d = acc_q - sext(wgt_q[idx_q]);
                end
                idx_d = idx_q + IdxW'(1);
                if (idx_q == IdxW'(N - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DONE: begin
                field_d = clip(acc_q);
                sat_d   = (acc_q > AccMax) || (acc_q < AccMin);
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control, accumulator and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            field_q <= 4'sd0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            field_q <= field_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
        end
    end

    // Weight/bias register file; addresses above N are silently ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= N; i++) begin
                wgt_q[i] <= '0;
            end
        end else if (wr_ok_s && (wr_addr_i <= AW'(N))) begin
            wgt_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign busy_o        = busy_q;
    assign field_out_o   = field_q;
    assign field_valid_o = valid_q;
    assign sat_o         = sat_q;

endmodule
